stack_unit: RTL and testbench
=============================

Name: stack_unit

Overview:
- Hardware LIFO operand stack of the multi-cycle stack CPU; sits directly downstream of the control unit, which drives push/pop/tos.
- Holds ALU operands and results. Pushed values come from the ALU result register or from memory data. Popped or peeked values feed the ALU operand registers, the memory write port and the JZ zero check.
- Single clock domain. Registered read output.

Parameters:
- DATA_W, 8, width of one stack entry
- DEPTH, 16, number of entries; must be a power of two, minimum 2
- PTR_W, $clog2(DEPTH), stack-pointer width; a count port of PTR_W+1 bits covers 0..DEPTH

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- push  input  1  write d_in to the top of stack this cycle
- pop  input  1  remove the top entry; its value appears on d_out next cycle
- tos  input  1  peek the top entry onto d_out next cycle; stack is unchanged
- d_in  input  DATA_W  value to push (ALU result or memory data, muxed upstream by stksrc)
- d_out  output  DATA_W  registered read data
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  PTR_W+1  current number of valid entries
- overflow  output  1  sticky: push attempted while full (STACK_ERR_EN only)
- underflow  output  1  sticky: pop or tos attempted while empty (STACK_ERR_EN only)
- clr_err  input  1  synchronous clear of the sticky flags (STACK_ERR_EN only)

Behaviour:
- Reset (rst low, asynchronous): sp=0, count=0, d_out=0, overflow=0, underflow=0, so empty=1 and full=0. Storage contents are not reset and are don't-care.
- sp points to the next free slot; the top of stack is mem[sp-1].
- Operations, all decoded on the rising clk edge:
  - push only, not full: mem[sp]<=d_in; sp<=sp+1; d_out holds.
  - pop only, not empty: d_out<=mem[sp-1]; sp<=sp-1.
  - tos only, not empty: d_out<=mem[sp-1]; sp unchanged.
  - push+pop together, not empty: replace. d_out<=old mem[sp-1]; mem[sp-1]<=d_in; sp unchanged.
  - push+pop together, empty: treated as an illegal pop. Nothing is written, sp unchanged, underflow set.
  - tos with push or pop: tos is ignored and the push/pop rule applies.
  - No strobe: full hold.
- Latency: d_out is valid exactly one cycle after a pop or tos strobe. The control unit sequence S_POP1 then S_POP2 then ALU therefore sees the first popped value during S_POP2 and the second during ALU.
- Boundaries:
  - push when full: ignored, no write, sp unchanged; overflow set.
  - pop or tos when empty: ignored, sp unchanged, d_out holds; underflow set.
  - sp never wraps.
  - full and empty are combinational from count and are never both 1.
- Reset asserted mid-operation aborts any in-flight strobe. The cycle after reset release starts from empty.

Optional Feature:
- Macro: STACK_ERR_EN.
- Defined: overflow and underflow are sticky registers, set as described under Behaviour. clr_err=1 clears both on the next edge; if an error event occurs in the same cycle as clr_err, set wins.
- Undefined: the overflow and underflow ports are tied to 0 and clr_err is unused. Illegal operations are still silently ignored with identical sp and d_out behaviour.

Decomposition:
- Shared package stack_pkg:
  - DATA_W and DEPTH defaults.
  - Typedef stack_word_t (DATA_W bits).
  - Typedef stack_ptr_t (PTR_W bits).
  - Enum stack_op_e {OP_NONE, OP_PUSH, OP_POP, OP_TOS, OP_REPL} used by the internal decode.
- Natural sub-module: stack_regfile, a DEPTH x DATA_W register array with one synchronous write port and one combinational read port. It is addressed by the parent, which owns sp, count, flags and the d_out register.

Test Plan:
- Reset then push 0x11, 0x22, 0x33; pop, pop, pop -> d_out reads 0x33, 0x22, 0x11 on the cycle after each pop; count goes 3, 2, 1, 0; empty=1 at the end.
- Push 0x05; tos twice -> d_out=0x05 both times, count stays 1; then pop -> d_out=0x05, count=0.
- Push 16 values with DEPTH=16 -> full=1; a 17th push of 0xAA is ignored, count=16, and popping returns the 16th value. With STACK_ERR_EN, overflow=1 until clr_err is pulsed.
- From empty, pop; then tos -> d_out unchanged, count=0; with STACK_ERR_EN, underflow=1; push+pop from empty also leaves count=0.
- Push 0x07; then push+pop with d_in=0x09 -> d_out=0x07, count=1; the next pop gives d_out=0x09.
- Push 3 entries, then assert rst low mid-cycle during a pop -> count=0, d_out=0, empty=1 immediately, with no clock edge required.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types for the operand stack of the stack CPU.
// Optional sticky error flags are enabled with the STACK_ERR_EN macro.
package stack_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_PTR_W  = $clog2(DEF_DEPTH);

    typedef logic [DEF_DATA_W-1:0] stack_word_t;
    typedef logic [DEF_PTR_W-1:0]  stack_ptr_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_TOS,
        OP_REPL
    } stack_op_e;

endpackage

// File: rtl/stack_unit_if.sv
// Control-unit to operand-stack bus: strobes in, data and status out.
// Overflow/underflow only carry information when STACK_ERR_EN is defined.
interface stack_unit_if #(
    parameter int DATA_W = stack_pkg::DEF_DATA_W,
    parameter int DEPTH  = stack_pkg::DEF_DEPTH
);
    localparam int PTR_W = $clog2(DEPTH);

    logic              push;
    logic              pop;
    logic              tos;
    logic              clr_err;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;
    logic              full;
    logic              empty;
    logic [PTR_W:0]    count;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, tos, clr_err, d_in,
        input  d_out, full, empty, count, overflow, underflow
    );

    modport slave (
        input  push, pop, tos, clr_err, d_in,
        output d_out, full, empty, count, overflow, underflow
    );

endinterface

// File: rtl/stack_regfile.sv
// Stack storage: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module stack_regfile #(
    parameter int DATA_W = stack_pkg::DEF_DATA_W,
    parameter int DEPTH  = stack_pkg::DEF_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write the addressed entry when enabled
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_unit.sv
// LIFO operand stack with registered read data and full/empty/count status.
// Define STACK_ERR_EN for sticky overflow/underflow flags cleared by clr_err.
module stack_unit
    import stack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    stack_unit_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]    count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] rd_data;
    logic [PTR_W-1:0]  top_idx;
    logic [PTR_W-1:0]  waddr;
    logic              we;
    logic              full, empty;
    logic              ovf_set, unf_set;
    stack_op_e         op;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign top_idx = PTR_W'(count_q - (PTR_W+1)'(1));

    // Decode strobes; push/pop dominate tos, push+pop is a replace
    always_comb begin
        op = OP_NONE;
        unique case (1'b1)
            bus.push && bus.pop:               op = OP_REPL;
            bus.push && !bus.pop:              op = OP_PUSH;
            !bus.push && bus.pop:              op = OP_POP;
            !bus.push && !bus.pop && bus.tos:  op = OP_TOS;
            default:                           op = OP_NONE;
        endcase
    end

    // Next pointer, read data, write strobe and error events
    always_comb begin
        count_d = count_q;
        dout_d  = dout_q;
        we      = 1'b0;
        waddr   = top_idx;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        unique case (op)
            OP_PUSH: begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    we      = 1'b1;
                    waddr   = count_q[PTR_W-1:0];
                    count_d = count_q + (PTR_W+1)'(1);
                end
            end
            OP_POP: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    dout_d  = rd_data;
                    count_d = count_q - (PTR_W+1)'(1);
                end
            end
            OP_TOS: begin
                if (empty) unf_set = 1'b1;
                else       dout_d  = rd_data;
            end
            OP_REPL: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    dout_d = rd_data;
                    we     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Stack pointer and registered read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    stack_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_regfile (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (bus.d_in),
        .raddr_i (top_idx),
        .rdata_o (rd_data)
    );

`ifdef STACK_ERR_EN
    logic ovf_q, unf_q;

    // Sticky error flags; a new event beats a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_set | (ovf_q & ~bus.clr_err);
            unf_q <= unf_set | (unf_q & ~bus.clr_err);
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`else
    logic unused_err;
    assign unused_err    = ^{bus.clr_err, ovf_set, unf_set};
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    assign bus.d_out = dout_q;
    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.count = count_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed testbench for stack_unit with hand-computed expectations.
// Error-flag expectations follow STACK_ERR_EN.
module tb_stack_unit;

`ifdef STACK_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    stack_unit_if #(.DATA_W(8), .DEPTH(16)) bus ();

    stack_unit #(.DATA_W(8), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic p, input logic q, input logic t,
                      input logic [7:0] d, input logic c);
        bus.push    = p;
        bus.pop     = q;
        bus.tos     = t;
        bus.d_in    = d;
        bus.clr_err = c;
        @(posedge clk);
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.tos     = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        op(1'b1, 1'b0, 1'b0, d, 1'b0);
    endtask

    task automatic pop();
        op(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic peek();
        op(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.tos     = 1'b0;
        bus.clr_err = 1'b0;
        bus.d_in    = 8'h00;
        #12;
        check("rst_count", 32'(bus.count), 0);
        check("rst_dout", 32'(bus.d_out), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full", 32'(bus.full), 0);
        check("rst_ovf", 32'(bus.overflow), 0);
        check("rst_unf", 32'(bus.underflow), 0);
        @(negedge clk);
        rst = 1'b1;

        // LIFO order
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check("lifo_cnt3", 32'(bus.count), 3);
        check("lifo_dout_hold", 32'(bus.d_out), 0);
        pop();
        check("lifo_pop1", 32'(bus.d_out), 32'h33);
        check("lifo_cnt2", 32'(bus.count), 2);
        pop();
        check("lifo_pop2", 32'(bus.d_out), 32'h22);
        check("lifo_cnt1", 32'(bus.count), 1);
        pop();
        check("lifo_pop3", 32'(bus.d_out), 32'h11);
        check("lifo_cnt0", 32'(bus.count), 0);
        check("lifo_empty", 32'(bus.empty), 1);

        // Peek
        push(8'h05);
        peek();
        check("tos1", 32'(bus.d_out), 32'h05);
        check("tos1_cnt", 32'(bus.count), 1);
        push(8'h06);
        pop();
        check("tos_mid_pop", 32'(bus.d_out), 32'h06);
        peek();
        check("tos2", 32'(bus.d_out), 32'h05);
        check("tos2_cnt", 32'(bus.count), 1);
        pop();
        check("tos_pop", 32'(bus.d_out), 32'h05);
        check("tos_pop_cnt", 32'(bus.count), 0);

        // Fill to full, overflow
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
        check("full_flag", 32'(bus.full), 1);
        check("full_cnt", 32'(bus.count), 16);
        check("full_notempty", 32'(bus.empty), 0);
        push(8'hAA);
        check("ovf_cnt", 32'(bus.count), 16);
        check("ovf_flag", 32'(bus.overflow), 32'(ERR));
        pop();
        check("ovf_pop", 32'(bus.d_out), 32'h8F);
        check("ovf_pop_cnt", 32'(bus.count), 15);
        check("ovf_sticky", 32'(bus.overflow), 32'(ERR));
        op(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("ovf_clr", 32'(bus.overflow), 0);
        for (int i = 0; i < 15; i++) pop();
        check("drain_last", 32'(bus.d_out), 32'h80);
        check("drain_empty", 32'(bus.empty), 1);

        // Underflow
        pop();
        check("unf_pop_dout", 32'(bus.d_out), 32'h80);
        check("unf_pop_cnt", 32'(bus.count), 0);
        check("unf_flag", 32'(bus.underflow), 32'(ERR));
        peek();
        check("unf_tos_dout", 32'(bus.d_out), 32'h80);
        check("unf_tos_cnt", 32'(bus.count), 0);
        op(1'b1, 1'b1, 1'b0, 8'h44, 1'b0);
        check("unf_repl_cnt", 32'(bus.count), 0);
        check("unf_repl_dout", 32'(bus.d_out), 32'h80);
        op(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("unf_clr", 32'(bus.underflow), 0);
        op(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        check("unf_set_wins", 32'(bus.underflow), 32'(ERR));
        op(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("unf_clr2", 32'(bus.underflow), 0);
        push(8'h66);
        pop();
        check("after_unf_pop", 32'(bus.d_out), 32'h66);

        // Replace
        push(8'h07);
        op(1'b1, 1'b1, 1'b0, 8'h09, 1'b0);
        check("repl_dout", 32'(bus.d_out), 32'h07);
        check("repl_cnt", 32'(bus.count), 1);
        pop();
        check("repl_pop", 32'(bus.d_out), 32'h09);
        check("repl_pop_cnt", 32'(bus.count), 0);

        // tos ignored alongside push
        push(8'h01);
        op(1'b1, 1'b0, 1'b1, 8'h02, 1'b0);
        check("tos_push_cnt", 32'(bus.count), 2);
        check("tos_push_dout", 32'(bus.d_out), 32'h09);
        pop();
        check("tos_push_pop", 32'(bus.d_out), 32'h02);

        // Async reset mid-pop
        push(8'h03);
        push(8'h04);
        bus.pop = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("arst_cnt", 32'(bus.count), 0);
        check("arst_dout", 32'(bus.d_out), 0);
        check("arst_empty", 32'(bus.empty), 1);
        @(posedge clk);
        #1;
        bus.pop = 1'b0;
        check("arst_hold_cnt", 32'(bus.count), 0);
        @(negedge clk);
        rst = 1'b1;
        push(8'h5A);
        check("arst_after_cnt", 32'(bus.count), 1);
        pop();
        check("arst_after_pop", 32'(bus.d_out), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
